// File: rtl/controle_contagem_if.sv
// Signal bundle between the count controller and its surroundings:
// raw buttons and counter value in, counter strobes and status out.
interface controle_contagem_if;
    // Strobe semantics: cnt_en and cnt_clr are single-cycle, registered,
    // mutually exclusive pulses; the counter acts on them at the rising
    // edge that ends the pulse cycle. There is no back-pressure, so a
    // pulse is consumed in the cycle it is presented.
    logic       btn_ss;
    logic       btn_clr;
    logic [3:0] q_in;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic       done;

    modport master (
        output btn_ss, btn_clr, q_in,
        input  cnt_en, cnt_clr, running, done
    );

    modport slave (
        input  btn_ss, btn_clr, q_in,
        output cnt_en, cnt_clr, running, done
    );
endinterface

// File: rtl/controle_contagem.sv
// Count controller: synchronizes and debounces the start/stop and clear
// buttons, divides the clock into a count tick, and sequences the
// downstream counter through IDLE/RUN/PAUSE/DONE.
module controle_contagem #(
    parameter int         DIV   = 10,
    parameter int         DEB   = 4,
    parameter logic [3:0] LIMIT = 4'd15
) (
    input  logic                clk,
    input  logic                rst,
    controle_contagem_if.slave  bus,
    output logic [1:0]          state_dbg
);

    localparam int             DW       = $clog2(DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [7:0]     DEB_LAST = 8'(DEB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit 0 is start/stop, bit 1 is clear.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      level_d;
    logic [1:0]      armed;
    logic [1:0]      sync_ok;
    logic [1:0][7:0] deb_cnt;
    logic [1:0]      press;
    logic [1:0]      press_next;

    state_t          state_q;
    state_t          state_n;
    logic [DW-1:0]   div_q;
    logic [DW-1:0]   div_n;
    logic            tick;
    logic            en_n;
    logic            clr_n;
    logic [3:0]      q_eff;
    logic            cnt_en_q;
    logic            cnt_clr_q;
    logic            running_q;
    logic            done_q;

    assign raw = {bus.btn_clr, bus.btn_ss};

    // A button is armed only once it has been seen released after reset,
    // so a button held through reset never produces a press.
    assign press = level & ~level_d & armed;

    // A press that will be presented in the next cycle; lets the registered
    // cnt_en be withheld for a tick that a press is about to pre-empt.
    always_comb begin
        press_next = '0;
        for (int i = 0; i < 2; i++) begin
            press_next[i] = armed[i] & ~level[i] & sync2[i] &
                            (deb_cnt[i] == DEB_LAST);
        end
    end

    // Two-flop synchronizers, debounce counters and press arming.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            armed   <= '0;
            sync_ok <= '0;
            deb_cnt <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            sync_ok <= {sync_ok[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        level[i]   <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
                if (sync_ok[1] && !sync2[i] && !level[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign tick = (state_q == RUN) && (div_q == DIV_LAST);

    // While cnt_clr is high the counter is cleared at this edge, so the
    // look-ahead for the next tick must see the cleared value.
    assign q_eff = cnt_clr_q ? 4'd0 : bus.q_in;

    // Next state, divider and the strobes to be registered at this edge.
    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        clr_n   = 1'b0;
        if (press[1]) begin
            state_n = IDLE;
            div_n   = '0;
            clr_n   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[0]) begin
                        state_n = RUN;
                        div_n   = '0;
                    end
                end
                RUN: begin
                    if (press[0]) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        div_n = '0;
                        if (bus.q_in == LIMIT) begin
                            state_n = DONE;
                        end
                    end else begin
                        div_n = div_q + DW'(1);
                    end
                end
                PAUSE: begin
                    if (press[0]) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                    if (press[0]) begin
                        state_n = RUN;
                        div_n   = '0;
                        clr_n   = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    div_n   = '0;
                end
            endcase
        end
        // cnt_en is registered one edge early so that it is high during the
        // tick cycle itself, unless that tick will be pre-empted by a press
        // or will find the counter at its limit.
        en_n = (state_n == RUN) && (div_n == DIV_LAST) &&
               (q_eff != LIMIT) && !press_next[0] && !press_next[1];
    end

    // State register, divider and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            cnt_en_q  <= en_n;
            cnt_clr_q <= clr_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == DONE);
        end
    end

    assign bus.cnt_en  = cnt_en_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_controle_contagem.sv
// Directed bench for controle_contagem with DIV=4, DEB=3, LIMIT=5 and a
// behavioural 4-bit counter closing the loop on cnt_en/cnt_clr.
module tb_controle_contagem;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;
    logic [3:0] model_q = 4'd0;
    int         en_count = 0;
    int         clr_count = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         snap;

    controle_contagem_if bus();

    controle_contagem #(
        .DIV   (4),
        .DEB   (3),
        .LIMIT (4'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Behavioural downstream counter.
    always @(posedge clk) begin
        if (!rst)             model_q <= 4'd0;
        else if (bus.cnt_clr) model_q <= 4'd0;
        else if (bus.cnt_en)  model_q <= model_q + 4'd1;
    end
    assign bus.q_in = model_q;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.cnt_en)  en_count  <= en_count + 1;
        if (bus.cnt_clr) clr_count <= clr_count + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        bus.btn_ss  = 1'b1;
        bus.btn_clr = 1'b1;
        rst = 1'b0;

        // Reset with both buttons held.
        step(3);
        rst = 1'b1;
        check_val("rst_en",      bus.cnt_en,  0);
        check_val("rst_clr",     bus.cnt_clr, 0);
        check_val("rst_running", bus.running, 0);
        check_val("rst_done",    bus.done,    0);
        check_val("rst_state",   state_dbg,   S_IDLE);
        step(15);
        check_val("held_state",  state_dbg,   S_IDLE);
        check_val("held_en",     en_count,    0);
        check_val("held_clr",    clr_count,   0);
        bus.btn_ss  = 1'b0;
        bus.btn_clr = 1'b0;
        step(10);
        check_val("rel_state",   state_dbg,   S_IDLE);
        check_val("rel_clr",     clr_count,   0);

        // Glitch rejection: two samples high.
        bus.btn_ss = 1'b1;
        step(2);
        bus.btn_ss = 1'b0;
        step(10);
        check_val("glitch_running", bus.running, 0);
        check_val("glitch_state",   state_dbg,   S_IDLE);

        // Run to limit: first high sample at edge k, press acted at k+5.
        bus.btn_ss = 1'b1;
        step(5);
        check_val("lat_running_early", bus.running, 0);
        step(1);
        check_val("lat_running", bus.running, 1);
        check_val("lat_state",   state_dbg,   S_RUN);
        snap = en_count;
        step(2);
        check_val("first_en_early", bus.cnt_en, 0);
        step(1);
        check_val("first_en", bus.cnt_en, 1);
        step(1);
        check_val("first_en_low", bus.cnt_en, 0);
        check_val("q_after_first", model_q, 1);
        bus.btn_ss = 1'b0;
        step(3);
        check_val("second_en", bus.cnt_en, 1);
        step(16);
        check_val("pre_done",    bus.done,    0);
        check_val("pre_running", bus.running, 1);
        step(1);
        check_val("done_high",    bus.done,       1);
        check_val("done_running", bus.running,    0);
        check_val("done_state",   state_dbg,      S_DONE);
        check_val("done_q",       model_q,        5);
        check_val("done_pulses",  en_count - snap, 5);
        step(12);
        check_val("done_hold_pulses", en_count - snap, 5);
        check_val("done_hold_q",      model_q,        5);
        check_val("done_hold_done",   bus.done,       1);

        // Restart from DONE.
        bus.btn_ss = 1'b1;
        step(5);
        bus.btn_ss = 1'b0;
        step(1);
        check_val("restart_clr",     bus.cnt_clr, 1);
        check_val("restart_en",      bus.cnt_en,  0);
        check_val("restart_running", bus.running, 1);
        check_val("restart_done",    bus.done,    0);
        check_val("restart_state",   state_dbg,   S_RUN);
        step(1);
        check_val("restart_clr_low", bus.cnt_clr, 0);
        check_val("restart_q0",      model_q,     0);
        step(2);
        check_val("restart_first_en", bus.cnt_en, 1);
        step(1);
        check_val("restart_q1", model_q, 1);

        // Pause with a 20-cycle hold, then resume.
        bus.btn_ss = 1'b1;
        step(5);
        check_val("prepause_running", bus.running, 1);
        step(1);
        check_val("pause_running", bus.running, 0);
        check_val("pause_state",   state_dbg,   S_PAUSE);
        check_val("pause_q",       model_q,     2);
        snap = en_count;
        step(14);
        bus.btn_ss = 1'b0;
        step(6);
        check_val("paused_state",  state_dbg,      S_PAUSE);
        check_val("paused_pulses", en_count - snap, 0);
        check_val("paused_q",      model_q,        2);
        bus.btn_ss = 1'b1;
        step(5);
        bus.btn_ss = 1'b0;
        step(1);
        check_val("resume_running", bus.running, 1);
        check_val("resume_state",   state_dbg,   S_RUN);
        step(1);
        check_val("resume_en_early", bus.cnt_en, 0);
        step(1);
        check_val("resume_en", bus.cnt_en, 1);
        step(1);
        check_val("resume_q", model_q, 3);

        // Clear and start/stop pressed together during RUN.
        step(1);
        bus.btn_ss  = 1'b1;
        bus.btn_clr = 1'b1;
        step(5);
        bus.btn_ss  = 1'b0;
        bus.btn_clr = 1'b0;
        snap = clr_count;
        step(1);
        check_val("both_clr",     bus.cnt_clr, 1);
        check_val("both_en",      bus.cnt_en,  0);
        check_val("both_state",   state_dbg,   S_IDLE);
        check_val("both_running", bus.running, 0);
        step(1);
        check_val("both_clr_low", bus.cnt_clr, 0);
        check_val("both_q",       model_q,     0);
        step(3);
        check_val("both_clr_once", clr_count - snap, 1);

        // Mid-run reset just before a cnt_en would rise.
        bus.btn_ss = 1'b1;
        step(5);
        bus.btn_ss = 1'b0;
        step(1);
        check_val("mid_running", bus.running, 1);
        step(2);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check_val("mid_en",      bus.cnt_en,  0);
        check_val("mid_clr",     bus.cnt_clr, 0);
        check_val("mid_running_low", bus.running, 0);
        check_val("mid_done",    bus.done,    0);
        check_val("mid_state",   state_dbg,   S_IDLE);
        snap = en_count;
        step(10);
        check_val("mid_after_pulses", en_count - snap, 0);
        check_val("mid_after_state",  state_dbg,      S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controle_contagem.md
# controle_contagem

Control stage directly upstream of the 4-bit binary counter. It debounces a start/stop button and a clear button, divides the system clock into a one-cycle count-enable tick, and runs an IDLE/RUN/PAUSE/DONE state machine. It feeds the counter its enable and clear strobes, and watches the counter's value so counting stops at a programmable limit.

## Interface
- DIV, 10: tick period in clock cycles; legal range 2..65535; divider width is $clog2(DIV).
- DEB, 4: debounce length in cycles; legal range 1..255.
- LIMIT, 4'd15: counter value at which counting stops.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets at the next rising edge of clk).
- btn_ss  input  1  raw start/stop button, asynchronous, active-high.
- btn_clr  input  1  raw clear button, asynchronous, active-high.
- q_in  input  4  current value of the downstream binary counter.
- cnt_en  output  1  one-cycle enable pulse; the counter increments on it.
- cnt_clr  output  1  one-cycle clear pulse to the counter.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.

## Operation
- Input conditioning: each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DEB consecutive cycles.
  - A rising edge of the debounced level produces one internal press event of one cycle.
  - A button held indefinitely yields exactly one press event.
  - A release must also be debounced before the next press is accepted.
- Divider: counts 0..DIV-1 only in RUN, and holds its value in PAUSE. It is cleared to 0 on entry to RUN from IDLE or DONE, and on any clear event.
- Tick: in RUN, a tick occurs in the cycle where the divider equals DIV-1. The divider then wraps to 0.
- State machine (reset state IDLE):
  - IDLE: ss press -> RUN.
  - RUN, ss press -> PAUSE.
  - RUN, tick with q_in != LIMIT -> cnt_en=1 for that cycle; stay in RUN.
  - RUN, tick with q_in == LIMIT -> no cnt_en; go to DONE.
  - PAUSE: ss press -> RUN; the divider resumes from its held value.
  - DONE: ss press -> cnt_clr pulse and go to RUN; the divider restarts at 0.
  - Any state: clr press -> cnt_clr pulse, divider 0, go to IDLE.
- Simultaneous events:
  - clr press has priority over ss press and over a tick.
  - An ss press in the same cycle as a tick in RUN goes to PAUSE and suppresses that cnt_en.
- All outputs are registered. cnt_en and cnt_clr are never high in the same cycle.

## Timing
- Reset: at the rising edge where rst=0, the following all go to 0: state=IDLE, divider, synchronizers, debounced levels, debounce counters, cnt_en, cnt_clr, running, done.
- Reset applied mid-operation aborts everything, with no trailing pulses.
- Button levels present during reset are not treated as presses afterwards. A button still held when reset releases must be released and pressed again.
- Press latency: if a raw button is first sampled high at edge k and stays high, the press event is acted on at edge k+DEB+2. At that edge the state, running/done and any cnt_clr update.
- Pulses shorter than DEB cycles after synchronization produce no press.
- First cnt_en after IDLE->RUN at edge m: high in the cycle following edge m+DIV-1. After that, exactly one cnt_en every DIV cycles while in RUN.
- PAUSE then resume: the time to the next cnt_en equals the DIV cycles remaining when paused.
- DONE entry: done rises at the edge ending the limiting tick. running falls at the same edge.

## Test plan
All scenarios use DIV=4, DEB=3, LIMIT=5, with a behavioural model counter driven by cnt_en/cnt_clr.

- Reset with both buttons held: rst=0 for 3 cycles, then release rst, keeping the buttons held -> all outputs 0, state stays IDLE, no cnt_en or cnt_clr until the buttons are released and pressed again.
- Glitch rejection: btn_ss high for 2 cycles, then 0 -> no press; running stays 0.
- Run to limit: btn_ss held for 10 cycles from edge k -> running=1 at edge k+5, and cnt_en pulses every 4 cycles. After the model counter reaches 5: done=1, running=0, no further cnt_en, q held at 5.
- Pause and resume: ss press in RUN -> running=0, no cnt_en while paused, q frozen. A second press -> running=1, and the next cnt_en arrives after the remaining divider cycles. A button held for 20 cycles gives only one transition.
- Clear priority: ss and clr pressed in the same cycle during RUN -> one-cycle cnt_clr, state IDLE, q=0. In DONE, an ss press -> cnt_clr plus RUN, and counting restarts from 0.
- Mid-run reset: rst=0 for one edge while in RUN -> cnt_en, cnt_clr, running and done all 0 from that edge; state IDLE.
